// File: rtl/pipeline_hazard_scheduler_pkg.sv
// Shared types and constants for the pipeline hazard scheduler: FSM states,
// forwarding select encodings and the PC register index.
package pipeline_hazard_scheduler_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/pipeline_hazard_scheduler_fwd_match.sv
// Forwarding comparator for one Execute-stage ALU operand: picks the youngest
// in-flight producer of the source register, never forwarding into R15 reads.
module hazard_fwd_match
    import pipeline_hazard_scheduler_pkg::*;
(
    input  logic [3:0] i_ra,
    input  logic [3:0] i_wa_m,
    input  logic [3:0] i_wa_w,
    input  logic       i_reg_write_m,
    input  logic       i_reg_write_w,
    output logic [1:0] o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    // R15 reads come from PC+8 in the datapath, so they are excluded up front.
    assign w_hit_m = i_reg_write_m && (i_ra == i_wa_m) && (i_ra != PC_REG);
    assign w_hit_w = i_reg_write_w && (i_ra == i_wa_w) && (i_ra != PC_REG);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m) begin
            o_fwd = FWD_M;
        end else if (w_hit_w) begin
            o_fwd = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Hazard controller for the 5-stage ARM pipeline: operand forwarding, stall and
// flush generation, and a data-memory wait FSM with a sticky timeout error.
module pipeline_hazard_scheduler
    import pipeline_hazard_scheduler_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [7:0] TIMEOUT_8 = 8'(MEM_TIMEOUT);

    hz_state_e        r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_ld_stall;
    logic       w_pc_pend;
    logic       w_mem_stall;
    logic       w_hold;

    hazard_fwd_match u_fwd_a (
        .i_ra          (RA1E),
        .i_wa_m        (WA3M),
        .i_wa_w        (WA3W),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_a)
    );

    hazard_fwd_match u_fwd_b (
        .i_ra          (RA2E),
        .i_wa_m        (WA3M),
        .i_wa_w        (WA3W),
        .i_reg_write_m (RegWriteM),
        .i_reg_write_w (RegWriteW),
        .o_fwd         (w_fwd_b)
    );

    assign w_ld_stall  = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign w_pc_pend   = PCSrcD || PCSrcE || PCSrcM;
    assign w_mem_stall = MemReqM && !MemReadyM;
    // ERROR freezes the pipeline regardless of what the memory does afterwards.
    assign w_hold      = w_mem_stall || (r_state == ERROR);

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        if (reset) begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            if (w_hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = w_ld_stall || w_pc_pend;
                StallD = w_ld_stall;
                FlushD = w_pc_pend || PCSrcW || BranchTakenE;
                FlushE = w_ld_stall || BranchTakenE;
                FlushW = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (StallF && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state <= RUN;
                    end else if ((r_wait_cnt + 8'd1) >= TIMEOUT_8) begin
                        r_state   <= ERROR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ERROR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign MemErr     = r_mem_err;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Bench for pipeline_hazard_scheduler: directed scenarios followed by a random
// run compared against a cycle-level behavioural model.
module tb_pipeline_hazard_scheduler;

    localparam int T_OUT = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWriteM, RegWriteW, MemtoRegE;
    logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic          MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM;
    logic          FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_scheduler #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        RA1D = 4'd1; RA2D = 4'd2; RA1E = 4'd3; RA2E = 4'd4;
        WA3E = 4'd6; WA3M = 4'd7; WA3W = 4'd8;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_idle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        RA1E = 4'd3; WA3M = 4'd3; RegWriteM = 1; MemReqM = 1; MemtoRegE = 1; WA3E = 4'd1;
        @(negedge clk);
        n_checks++;
        if ({ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 11'b0000_0000_111) begin
            n_fail++;
            $display("FAIL reset_forced: got fa=%b fb=%b s=%b%b%b%b f=%b%b%b want 00 00 0000 111",
                     ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW);
        end
        next_cycle();
        n_checks++;
        if (StallCount !== '0 || MemErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got cnt=%0d err=%b want 0 0", StallCount, MemErr);
        end
        reset = 1'b1;
        set_idle();
    endtask

    task automatic test_forwarding();
        do_reset();
        RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; RegWriteM = 1; WA3W = 4'd3; RegWriteW = 1;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_m_priority: got %b/%b want 10/10", ForwardAE, ForwardBE);
        end
        RegWriteM = 0;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_w: got %b/%b want 01/01", ForwardAE, ForwardBE);
        end
        RA1E = 4'd15; WA3W = 4'd15;
        #1;
        n_checks++;
        if (ForwardAE !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_pc: got %b want 00", ForwardAE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        MemtoRegE = 1; WA3E = 4'd5; RA2D = 4'd5;
        @(negedge clk);
        n_checks++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
            n_fail++;
            $display("FAIL load_use: got sf=%b sd=%b fe=%b fd=%b want 1 1 1 0", StallF, StallD, FlushE, FlushD);
        end
        next_cycle();
        MemtoRegE = 0;
        @(negedge clk);
        n_checks++;
        if ({StallF, StallD, FlushE, StallCount} !== {3'b000, 4'd1}) begin
            n_fail++;
            $display("FAIL load_use_release: got sf=%b sd=%b fe=%b cnt=%0d want 0 0 0 1",
                     StallF, StallD, FlushE, StallCount);
        end
    endtask

    task automatic test_branch();
        do_reset();
        BranchTakenE = 1;
        @(negedge clk);
        n_checks++;
        if ({FlushD, FlushE, StallF} !== 3'b110) begin
            n_fail++;
            $display("FAIL branch: got fd=%b fe=%b sf=%b want 1 1 0", FlushD, FlushE, StallF);
        end
        next_cycle();
        BranchTakenE = 0;
        for (int i = 0; i < 5; i++) begin
            {PCSrcW, PCSrcM, PCSrcE, PCSrcD} = (i < 4) ? (4'b0001 << i) : 4'b0000;
            @(negedge clk);
            n_checks++;
            if (StallF !== (i < 3) || FlushD !== (i < 4)) begin
                n_fail++;
                $display("FAIL pc_write_step%0d: got sf=%b fd=%b want %b %b", i, StallF, FlushD, i < 3, i < 4);
            end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        BranchTakenE = 1;
        MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            MemReadyM = (i == 3);
            @(negedge clk);
            n_checks++;
            if (i < 3) begin
                if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b11111_00) begin
                    n_fail++;
                    $display("FAIL mem_wait_%0d: got s=%b%b%b%b fw=%b fd=%b fe=%b want 1111 1 0 0",
                             i, StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE);
                end
            end else if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b00000_11) begin
                n_fail++;
                $display("FAIL mem_release: got s=%b%b%b%b fw=%b fd=%b fe=%b want 0000 0 1 1",
                         StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE);
            end
            next_cycle();
        end
        BranchTakenE = 0;
        MemReqM = 1; MemReadyM = 1;
        @(negedge clk);
        n_checks++;
        if (StallCount !== 4'd3 || MemErr !== 1'b0 || StallF !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_after: got cnt=%0d err=%b sf=%b want 3 0 0", StallCount, MemErr, StallF);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (MemErr !== (i >= T_OUT) || StallF !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_%0d: got err=%b sf=%b want %b 1", i, MemErr, StallF, i >= T_OUT);
            end
            next_cycle();
        end
        MemReqM = 0; MemReadyM = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({MemErr, StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 8'b111111_00) begin
                n_fail++;
                $display("FAIL error_sticky_%0d: got err=%b s=%b%b%b%b fw=%b fd=%b fe=%b want 1 1111 1 0 0",
                         i, MemErr, StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE);
            end
            next_cycle();
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (MemErr !== 1'b0 || StallCount !== '0 || StallF !== 1'b0) begin
            n_fail++;
            $display("FAIL error_reset: got err=%b cnt=%0d sf=%b want 0 0 0", MemErr, StallCount, StallF);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        PCSrcD = 1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (StallCount !== CW'((i < CMAX) ? i : CMAX)) begin
                n_fail++;
                $display("FAIL saturate_%0d: got %0d want %0d", i, StallCount, (i < CMAX) ? i : CMAX);
            end
            next_cycle();
        end
        set_idle();
    endtask

    function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input logic wm, input logic [3:0] am,
                                           input logic ww, input logic [3:0] aw);
        if (ra == 4'd15) return 2'b00;
        if (wm && ra == am) return 2'b10;
        if (ww && ra == aw) return 2'b01;
        return 2'b00;
    endfunction

    task automatic test_random();
        bit          m_err = 0;
        int          m_wait = 0;
        int          m_cnt = 0;
        logic [12:0] exp_vec, got_vec;
        logic        sf, ldu, pcp, hold;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 49) != 0);
            RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
            RA1E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            RA2E = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            WA3E = 4'($urandom_range(0, 3));
            WA3M = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            WA3W = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            MemtoRegE = ($urandom_range(0, 3) == 0);
            PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
            PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            MemReqM = (m_wait > 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 2) == 0);

            ldu  = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
            pcp  = PCSrcD || PCSrcE || PCSrcM;
            hold = m_err || (MemReqM && !MemReadyM);
            if (!reset) begin
                sf = 0;
                exp_vec = {4'b0000, 4'b0000, 3'b111, m_err};
            end else if (hold) begin
                sf = 1;
                exp_vec = {ref_fwd(RA1E, RegWriteM, WA3M, RegWriteW, WA3W),
                           ref_fwd(RA2E, RegWriteM, WA3M, RegWriteW, WA3W),
                           4'b1111, 3'b001, m_err};
            end else begin
                sf = ldu || pcp;
                exp_vec = {ref_fwd(RA1E, RegWriteM, WA3M, RegWriteW, WA3W),
                           ref_fwd(RA2E, RegWriteM, WA3M, RegWriteW, WA3W),
                           sf, ldu, 2'b00, pcp || PCSrcW || BranchTakenE, ldu || BranchTakenE, 1'b0, m_err};
            end

            @(negedge clk);
            got_vec = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr};
            n_checks++;
            if (got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rand_outputs cyc%0d: got %b want %b (fa fb sf sd se sm fd fe fw err)", c, got_vec, exp_vec);
            end
            n_checks++;
            if (StallCount !== CW'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_count cyc%0d: got %0d want %0d", c, StallCount, m_cnt);
            end

            if (!reset) begin
                m_err = 0; m_wait = 0; m_cnt = 0;
            end else begin
                if (sf && m_cnt < CMAX) m_cnt++;
                if (!m_err) begin
                    if (MemReqM && !MemReadyM) begin
                        m_wait++;
                        if (m_wait >= T_OUT) m_err = 1;
                    end else begin
                        m_wait = 0;
                    end
                end
            end
            next_cycle();
        end
        reset = 1'b1;
        set_idle();
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        next_cycle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
